// File: rtl/cpu_control_fsm.sv
// Moore control FSM for the 16-bit RISC core: fetch, decode, execute, writeback.
// Optional SINGLE_STEP_EN adds a `step` input that pauses before every fetch.
module cpu_control_fsm #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SINGLE_STEP_EN
    input  logic       step,
`endif
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       loadir,
    output logic       loadpc,
    output logic       pcreset,
    output logic       msel,
    output logic       loadaddr,
    output logic       mwrite,
    output logic [2:0] nsel,
    output logic       write,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       halted
);

    typedef enum logic [4:0] {
        RST, IF1, IF2, UPDATE_PC, DECODE, WR_IMM, GET_A, GET_B, EXEC, EXEC_S,
        WR_REG, ADDR, LD_ADDR, MEM_RD, WR_MEM, GET_BD, MEM_WR, HALT
`ifdef SINGLE_STEP_EN
        , WAIT_STEP
`endif
    } state_t;

    // Instruction class latched in DECODE so later states never look at opcode/op.
    typedef enum logic [2:0] {K_ALU, K_MOVR, K_CMP, K_MVN, K_LDR, K_STR} kind_t;

    localparam logic [1:0] LAT_MAX = 2'(MEM_LAT - 1);

`ifdef SINGLE_STEP_EN
    localparam state_t END_ST = WAIT_STEP;
`else
    localparam state_t END_ST = IF1;
`endif

    state_t     state, next_state;
    kind_t      kind, next_kind;
    logic [1:0] wait_cnt;

    // Wait counter restarts outside the two memory-wait states and saturates inside them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RST;
            kind     <= K_ALU;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            kind  <= next_kind;
            if (state != IF1 && state != MEM_RD)
                wait_cnt <= '0;
            else if (wait_cnt != LAT_MAX)
                wait_cnt <= wait_cnt + 2'd1;
        end
    end

    always_comb begin
        next_state = state;
        next_kind  = kind;
        loadir     = 1'b0;
        loadpc     = 1'b0;
        pcreset    = 1'b0;
        msel       = 1'b0;
        loadaddr   = 1'b0;
        mwrite     = 1'b0;
        nsel       = 3'b000;
        write      = 1'b0;
        vsel       = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        halted     = 1'b0;
        case (state)
            RST: begin
                pcreset    = 1'b1;
                loadpc     = 1'b1;
                next_state = END_ST;
            end
            IF1: if (wait_cnt == LAT_MAX) next_state = IF2;
            IF2: begin
                loadir     = 1'b1;
                next_state = UPDATE_PC;
            end
            UPDATE_PC: begin
                loadpc     = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                nsel = 3'b001;
                case (opcode)
                    3'b110: begin
                        if (op == 2'b10) next_state = WR_IMM;
                        else if (op == 2'b00) begin
                            next_state = GET_B;
                            next_kind  = K_MOVR;
                        end else next_state = HALT;
                    end
                    3'b101: begin
                        case (op)
                            2'b00: begin next_state = GET_A; next_kind = K_ALU; end
                            2'b01: begin next_state = GET_A; next_kind = K_CMP; end
                            2'b10: begin next_state = GET_A; next_kind = K_ALU; end
                            2'b11: begin next_state = GET_B; next_kind = K_MVN; end
                        endcase
                    end
                    3'b011: begin next_state = GET_A; next_kind = K_LDR; end
                    3'b100: begin next_state = GET_A; next_kind = K_STR; end
                    default: next_state = HALT;
                endcase
            end
            WR_IMM: begin
                nsel       = 3'b001;
                vsel       = 2'b01;
                write      = 1'b1;
                next_state = END_ST;
            end
            GET_A: begin
                nsel       = 3'b001;
                loada      = 1'b1;
                next_state = (kind == K_LDR || kind == K_STR) ? ADDR : GET_B;
            end
            GET_B: begin
                nsel       = 3'b100;
                loadb      = 1'b1;
                next_state = (kind == K_CMP) ? EXEC_S : EXEC;
            end
            EXEC: begin
                loadc      = 1'b1;
                asel       = (kind == K_MOVR);
                next_state = WR_REG;
            end
            EXEC_S: begin
                loads      = 1'b1;
                next_state = END_ST;
            end
            WR_REG: begin
                nsel       = 3'b010;
                write      = 1'b1;
                next_state = END_ST;
            end
            ADDR: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                next_state = LD_ADDR;
            end
            LD_ADDR: begin
                loadaddr   = 1'b1;
                next_state = (kind == K_STR) ? GET_BD : MEM_RD;
            end
            MEM_RD: begin
                msel = 1'b1;
                if (wait_cnt == LAT_MAX) next_state = WR_MEM;
            end
            WR_MEM: begin
                msel       = 1'b1;
                nsel       = 3'b010;
                vsel       = 2'b10;
                write      = 1'b1;
                next_state = END_ST;
            end
            GET_BD: begin
                nsel       = 3'b010;
                loadb      = 1'b1;
                next_state = MEM_WR;
            end
            MEM_WR: begin
                msel       = 1'b1;
                mwrite     = 1'b1;
                next_state = END_ST;
            end
            HALT: halted = 1'b1;
`ifdef SINGLE_STEP_EN
            WAIT_STEP: if (step) next_state = IF1;
`endif
            // Unreachable encodings behave like RST and recover on the next edge.
            default: begin
                pcreset    = 1'b1;
                loadpc     = 1'b1;
                next_state = RST;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: two instances (MEM_LAT 1 and 2) checked
// cycle by cycle against hand-written per-state output tables.
module tb_cpu_control_fsm;

    typedef struct packed {
        logic       loadir, loadpc, pcreset, msel, loadaddr, mwrite;
        logic [2:0] nsel;
        logic       write;
        logic [1:0] vsel;
        logic       loada, loadb, loadc, loads, asel, bsel, halted;
    } outs_t;

    typedef enum int {
        S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WRIMM, S_GETA, S_GETB, S_EXEC, S_EXECMOV,
        S_EXECS, S_WRREG, S_ADDR, S_LDADDR, S_MEMRD, S_WRMEM, S_GETBD, S_MEMWR, S_HALT
    } sid_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode_a, opcode_b;
    logic [1:0] op_a, op_b;

    logic       a_loadir, a_loadpc, a_pcreset, a_msel, a_loadaddr, a_mwrite, a_write;
    logic       a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel, a_halted;
    logic [2:0] a_nsel;
    logic [1:0] a_vsel;
    logic       b_loadir, b_loadpc, b_pcreset, b_msel, b_loadaddr, b_mwrite, b_write;
    logic       b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_halted;
    logic [2:0] b_nsel;
    logic [1:0] b_vsel;

    outs_t act_a, act_b;
    outs_t qa[$], qb[$];
    string na[$], nb[$];
    int    n_vec = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    cpu_control_fsm #(.MEM_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .opcode(opcode_a), .op(op_a),
        .loadir(a_loadir), .loadpc(a_loadpc), .pcreset(a_pcreset), .msel(a_msel),
        .loadaddr(a_loadaddr), .mwrite(a_mwrite), .nsel(a_nsel), .write(a_write),
        .vsel(a_vsel), .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc),
        .loads(a_loads), .asel(a_asel), .bsel(a_bsel), .halted(a_halted)
    );

    cpu_control_fsm #(.MEM_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .opcode(opcode_b), .op(op_b),
        .loadir(b_loadir), .loadpc(b_loadpc), .pcreset(b_pcreset), .msel(b_msel),
        .loadaddr(b_loadaddr), .mwrite(b_mwrite), .nsel(b_nsel), .write(b_write),
        .vsel(b_vsel), .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc),
        .loads(b_loads), .asel(b_asel), .bsel(b_bsel), .halted(b_halted)
    );

    assign act_a = {a_loadir, a_loadpc, a_pcreset, a_msel, a_loadaddr, a_mwrite, a_nsel, a_write,
                    a_vsel, a_loada, a_loadb, a_loadc, a_loads, a_asel, a_bsel, a_halted};
    assign act_b = {b_loadir, b_loadpc, b_pcreset, b_msel, b_loadaddr, b_mwrite, b_nsel, b_write,
                    b_vsel, b_loada, b_loadb, b_loadc, b_loads, b_asel, b_bsel, b_halted};

    // Expected Moore outputs of each state, written out by hand.
    function automatic outs_t expect_of(input sid_t s);
        outs_t e;
        e = '0;
        case (s)
            S_RST:     begin e.pcreset = 1'b1; e.loadpc = 1'b1; end
            S_IF1:     ;
            S_IF2:     e.loadir = 1'b1;
            S_UPC:     e.loadpc = 1'b1;
            S_DEC:     e.nsel = 3'b001;
            S_WRIMM:   begin e.nsel = 3'b001; e.vsel = 2'b01; e.write = 1'b1; end
            S_GETA:    begin e.nsel = 3'b001; e.loada = 1'b1; end
            S_GETB:    begin e.nsel = 3'b100; e.loadb = 1'b1; end
            S_EXEC:    e.loadc = 1'b1;
            S_EXECMOV: begin e.loadc = 1'b1; e.asel = 1'b1; end
            S_EXECS:   e.loads = 1'b1;
            S_WRREG:   begin e.nsel = 3'b010; e.vsel = 2'b00; e.write = 1'b1; end
            S_ADDR:    begin e.bsel = 1'b1; e.loadc = 1'b1; end
            S_LDADDR:  e.loadaddr = 1'b1;
            S_MEMRD:   e.msel = 1'b1;
            S_WRMEM:   begin e.msel = 1'b1; e.nsel = 3'b010; e.vsel = 2'b10; e.write = 1'b1; end
            S_GETBD:   begin e.nsel = 3'b010; e.loadb = 1'b1; end
            S_MEMWR:   begin e.msel = 1'b1; e.mwrite = 1'b1; end
            S_HALT:    e.halted = 1'b1;
            default:   ;
        endcase
        return e;
    endfunction

    task automatic push_exp(input bit d, input sid_t s, input string nm);
        if (d) begin
            qb.push_back(expect_of(s));
            nb.push_back(nm);
        end else begin
            qa.push_back(expect_of(s));
            na.push_back(nm);
        end
    endtask

    task automatic set_ops(input bit d, input logic [2:0] opc, input logic [1:0] o);
        if (d) begin
            opcode_b = opc;
            op_b     = o;
        end else begin
            opcode_a = opc;
            op_a     = o;
        end
    endtask

    // Called just after a clock edge; reset is asserted between edges so the
    // first RST check lands before any further clock edge.
    task automatic do_reset();
        reset = 1'b0;
        push_exp(1'b0, S_RST, "reset_async");
        push_exp(1'b1, S_RST, "reset_async");
        @(posedge clk); #1;
        push_exp(1'b0, S_RST, "reset_release");
        push_exp(1'b1, S_RST, "reset_release");
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // Issues one instruction from IF1; the opcode inputs are scrambled once DECODE is over.
    task automatic applyStimulus(input bit d, input logic [2:0] opc, input logic [1:0] o,
                                 input string nm, input int hold);
        int   lat;
        sid_t seq[$];
        lat = d ? 2 : 1;
        for (int i = 0; i < lat; i++) seq.push_back(S_IF1);
        seq.push_back(S_IF2);
        seq.push_back(S_UPC);
        seq.push_back(S_DEC);
        if (opc == 3'b110 && o == 2'b10) begin
            seq.push_back(S_WRIMM);
        end else if (opc == 3'b110 && o == 2'b00) begin
            seq.push_back(S_GETB); seq.push_back(S_EXECMOV); seq.push_back(S_WRREG);
        end else if (opc == 3'b101 && o == 2'b01) begin
            seq.push_back(S_GETA); seq.push_back(S_GETB); seq.push_back(S_EXECS);
        end else if (opc == 3'b101 && o == 2'b11) begin
            seq.push_back(S_GETB); seq.push_back(S_EXEC); seq.push_back(S_WRREG);
        end else if (opc == 3'b101) begin
            seq.push_back(S_GETA); seq.push_back(S_GETB); seq.push_back(S_EXEC);
            seq.push_back(S_WRREG);
        end else if (opc == 3'b011) begin
            seq.push_back(S_GETA); seq.push_back(S_ADDR); seq.push_back(S_LDADDR);
            for (int i = 0; i < lat; i++) seq.push_back(S_MEMRD);
            seq.push_back(S_WRMEM);
        end else if (opc == 3'b100) begin
            seq.push_back(S_GETA); seq.push_back(S_ADDR); seq.push_back(S_LDADDR);
            seq.push_back(S_GETBD); seq.push_back(S_MEMWR);
        end else begin
            for (int i = 0; i < hold; i++) seq.push_back(S_HALT);
        end
        set_ops(d, opc, o);
        for (int i = 0; i < seq.size(); i++) push_exp(d, seq[i], $sformatf("%s[%0d]", nm, i));
        repeat (lat + 3) @(posedge clk);
        #1;
        set_ops(d, 3'b110, 2'b10);
        repeat (seq.size() - lat - 3) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int d, input outs_t act, input outs_t exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s (dut%0d): got %05h expected %05h", nm, d, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) checkOutput(0, act_a, qa.pop_front(), na.pop_front());
        if (qb.size() > 0) checkOutput(1, act_b, qb.pop_front(), nb.pop_front());
    end

    initial begin
        reset    = 1'b1;
        opcode_a = 3'b110; op_a = 2'b10;
        opcode_b = 3'b110; op_b = 2'b10;
        @(posedge clk); #1;
        do_reset();

        fork
            begin
                applyStimulus(1'b0, 3'b110, 2'b10, "mov_imm", 0);
                applyStimulus(1'b0, 3'b110, 2'b00, "mov_reg", 0);
                applyStimulus(1'b0, 3'b101, 2'b00, "add", 0);
                applyStimulus(1'b0, 3'b101, 2'b10, "and", 0);
                applyStimulus(1'b0, 3'b101, 2'b01, "cmp", 0);
                applyStimulus(1'b0, 3'b101, 2'b11, "mvn", 0);
                applyStimulus(1'b0, 3'b011, 2'b00, "ldr", 0);
                applyStimulus(1'b0, 3'b100, 2'b00, "str", 0);
            end
            begin
                applyStimulus(1'b1, 3'b011, 2'b00, "ldr_lat2", 0);
                applyStimulus(1'b1, 3'b101, 2'b00, "add_lat2", 0);
                applyStimulus(1'b1, 3'b100, 2'b00, "str_lat2", 0);
            end
        join

        do_reset();

        // STR cut short by reset while in GET_BD: MEM_WR must never appear.
        set_ops(1'b0, 3'b100, 2'b00);
        push_exp(1'b0, S_IF1, "str_cut[0]");
        push_exp(1'b0, S_IF2, "str_cut[1]");
        push_exp(1'b0, S_UPC, "str_cut[2]");
        push_exp(1'b0, S_DEC, "str_cut[3]");
        push_exp(1'b0, S_GETA, "str_cut[4]");
        push_exp(1'b0, S_ADDR, "str_cut[5]");
        push_exp(1'b0, S_LDADDR, "str_cut[6]");
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        applyStimulus(1'b0, 3'b101, 2'b10, "and_after_rst", 0);

        applyStimulus(1'b0, 3'b111, 2'b00, "halt", 6);
        do_reset();
        applyStimulus(1'b0, 3'b001, 2'b00, "undef_opcode", 4);
        do_reset();
        applyStimulus(1'b0, 3'b110, 2'b01, "mov_bad_op", 3);
        do_reset();
        applyStimulus(1'b0, 3'b110, 2'b10, "mov_imm_final", 0);

        for (int i = 0; i < 20 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
        n_vec++;
        if ((qa.size() + qb.size()) != 0) begin
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
